// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle logic/arith/compare ops plus an
// iterative restoring signed/unsigned divider behind a valid/ready handshake.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_NOR  = 5'b00011;
    localparam logic [4:0] OP_LUI  = 5'b00100;
    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_ADDU = 5'b10001;
    localparam logic [4:0] OP_SUB  = 5'b10010;
    localparam logic [4:0] OP_SUBU = 5'b10011;
    localparam logic [4:0] OP_SLT  = 5'b10100;
    localparam logic [4:0] OP_SLTU = 5'b10101;
    localparam logic [4:0] OP_DIV  = 5'b11000;
    localparam logic [4:0] OP_DIVU = 5'b11001;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             is_div, a_neg, b_neg, accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, diff;
    logic             take;
    logic [WIDTH-1:0] quo_n, rem_n, q_fin, r_fin;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        sum    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        dif    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        sc_res = '0;
        sc_ovf = 1'b0;
        case (op)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_LUI:  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_ovf = sum[WIDTH] ^ sum[WIDTH-1];
            end
            OP_ADDU: sc_res = sum[WIDTH-1:0];
            OP_SUB: begin
                sc_res = dif[WIDTH-1:0];
                sc_ovf = dif[WIDTH] ^ dif[WIDTH-1];
            end
            OP_SUBU: sc_res = dif[WIDTH-1:0];
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        is_div = (op == OP_DIV) | (op == OP_DIVU);
        a_neg  = (op == OP_DIV) & a[WIDTH-1];
        b_neg  = (op == OP_DIV) & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // quo_q shifts dividend bits out the top while quotient bits enter below
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        take   = ~diff[WIDTH];
        quo_n  = {quo_q[WIDTH-2:0], take};
        rem_n  = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        q_fin  = qneg_q ? -quo_n : quo_n;
        r_fin  = rneg_q ? -rem_n : rem_n;
        if (dvsr_q == '0) begin
            q_fin = '1;
            r_fin = a_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;
        dvsr_d      = dvsr_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        a_d         = a_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE && out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                    if (accept && is_div) begin
                        dvsr_d      = b_mag;
                        quo_d       = a_mag;
                        rem_d       = '0;
                        a_d         = a;
                        qneg_d      = a_neg ^ b_neg;
                        rneg_d      = a_neg;
                        cnt_d       = CW'(WIDTH - 1);
                        state_d     = S_DIV;
                        out_valid_d = 1'b0;
                    end else if (accept) begin
                        result_d    = sc_res;
                        hi_d        = '0;
                        ovf_d       = sc_ovf;
                        zero_d      = (sc_res == '0);
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end
                S_DIV: begin
                    quo_d = quo_n;
                    rem_d = rem_n;
                    if (cnt_q == '0) begin
                        result_d    = q_fin;
                        hi_d        = r_fin;
                        ovf_d       = 1'b0;
                        zero_d      = (q_fin == '0);
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            cnt_q       <= '0;
            dvsr_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            a_q         <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
            dvsr_q      <= dvsr_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            a_q         <= a_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table, handshake/flush/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_mc;
    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, hi;
    logic        overflow, zero;

    logic        r16_n;
    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [4:0]  c_op;
    logic [15:0] c_a, c_b, c_result, c_hi;
    logic        c_overflow, c_zero;

    int errors = 0;
    int checks = 0;

    alu_mc #(.WIDTH(32)) u32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .hi(hi), .overflow(overflow), .zero(zero)
    );

    alu_mc #(.WIDTH(16)) u16 (
        .clk(clk), .resetn(r16_n), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .op(c_op), .a(c_a),
        .b(c_b), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .result(c_result), .hi(c_hi), .overflow(c_overflow), .zero(c_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic [31:0] eh;
        logic        eo;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] r,
                         output logic [31:0] h, output logic ov);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = 0; h = 0; ov = 0;
        case (o)
            5'b00111: r = x & y;
            5'b00001: r = x | y;
            5'b00010: r = x ^ y;
            5'b00011: r = ~(x | y);
            5'b00100: r = y << 16;
            5'b10000: begin
                s = sx + sy; r = 32'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'b10001: r = x + y;
            5'b10010: begin
                s = sx - sy; r = 32'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'b10011: r = x - y;
            5'b10100: r = (sx < sy) ? 1 : 0;
            5'b10101: r = (x < y) ? 1 : 0;
            5'b11000: begin
                if (y == 0) begin r = '1; h = x; end
                else if (x == 32'h80000000 && y == 32'hffffffff) begin
                    r = x; h = 0;
                end else begin
                    r = 32'(sx / sy); h = 32'(sx % sy);
                end
            end
            5'b11001: begin
                if (y == 0) begin r = '1; h = x; end
                else begin r = x / y; h = x % y; end
            end
            default: r = 0;
        endcase
    endtask

    task automatic run32(input string tag, input logic [4:0] o,
                         input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [31:0] er, input logic [31:0] eh,
                         input logic eo, input int elat);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1; op = o; a = ta; b = tb_; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_res"}, result, er);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_ovf"}, overflow, eo);
        chk({tag, "_zero"}, zero, er == 0);
    endtask

    vec_t vt[11];
    logic [4:0] codes[15];

    initial begin
        logic [31:0] mr, mh, ra, rb, held;
        logic        mo;
        logic [4:0]  ro;
        int          lat, seen;

        vt[0]  = '{5'b10000, 32'h7fffffff, 32'h1, 32'h80000000, 32'h0, 1'b1, 1};
        vt[1]  = '{5'b10001, 32'h7fffffff, 32'h1, 32'h80000000, 32'h0, 1'b0, 1};
        vt[2]  = '{5'b10100, 32'hffffffff, 32'h1, 32'h1, 32'h0, 1'b0, 1};
        vt[3]  = '{5'b10101, 32'hffffffff, 32'h1, 32'h0, 32'h0, 1'b0, 1};
        vt[4]  = '{5'b10010, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 1};
        vt[5]  = '{5'b11000, 32'hfffffff9, 32'h2, 32'hfffffffd, 32'hffffffff, 1'b0, 33};
        vt[6]  = '{5'b11001, 32'h7, 32'h0, 32'hffffffff, 32'h7, 1'b0, 33};
        vt[7]  = '{5'b11000, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h0, 1'b0, 33};
        vt[8]  = '{5'b01010, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 1};
        vt[9]  = '{5'b10010, 32'h80000000, 32'h1, 32'h7fffffff, 32'h0, 1'b1, 1};
        vt[10] = '{5'b11000, 32'h64, 32'hfffffff9, 32'hfffffff2, 32'h2, 1'b0, 33};
        codes = '{5'b00111, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                  5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100,
                  5'b10101, 5'b11000, 5'b11001, 5'b00000, 5'b11111};

        resetn = 0; r16_n = 0; flush = 0; in_valid = 0; op = 0;
        a = 0; b = 0; out_ready = 0;
        c_flush = 0; c_in_valid = 0; c_op = 0; c_a = 0; c_b = 0;
        c_out_ready = 0;
        repeat (3) @(negedge clk);
        resetn = 1; r16_n = 1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_hi", hi, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_zero", zero, 1);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 11; i++)
            run32($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                  vt[i].er, vt[i].eh, vt[i].eo, vt[i].lat);

        // back-to-back single-cycle ops
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 5'b00111;
        a = 32'hf0f0_1234; b = 32'h0ff0_ffff;
        @(negedge clk);
        chk("b2b_v0", out_valid, 1);
        chk("b2b_and", result, 32'h00f0_1234);
        op = 5'b00001;
        @(negedge clk);
        chk("b2b_v1", out_valid, 1);
        chk("b2b_or", result, 32'hfff0_ffff);
        op = 5'b00100; b = 32'h0000_1234;
        @(negedge clk);
        chk("b2b_v2", out_valid, 1);
        chk("b2b_lui", result, 32'h1234_0000);
        in_valid = 0;
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

        // stall with out_ready low
        in_valid = 1; op = 5'b00010; a = 32'haaaa_0000; b = 32'h0000_5555;
        out_ready = 0;
        @(negedge clk);
        held = result;
        op = 5'b00111;
        chk("stall_val", held, 32'haaaa_5555);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", result, held);
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);

        // flush during divide
        in_valid = 1; op = 5'b11000; a = 32'd100; b = 32'd7;
        @(negedge clk);
        in_valid = 0;
        repeat (8) @(negedge clk);
        chk("div_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1; in_valid = 1; op = 5'b10000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("flush_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("flush_no_valid", seen, 0);
        run32("post_flush_add", 5'b10000, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1);

        // randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = codes[$urandom_range(0, 14)];
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: rb = $urandom_range(1, 9);
                2: rb = -$urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            model(ro, ra, rb, mr, mh, mo);
            run32($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb, mr, mh, mo,
                  (ro == 5'b11000 || ro == 5'b11001) ? 33 : 1);
        end

        // WIDTH=16 signed minimum / -1
        @(negedge clk);
        c_in_valid = 1; c_op = 5'b11000; c_a = 16'h8000; c_b = 16'hffff;
        c_out_ready = 1;
        @(negedge clk);
        c_in_valid = 0;
        lat = 1;
        while (!c_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_lat", lat, 17);
        chk("w16_res", c_result, 16'h8000);
        chk("w16_hi", c_hi, 0);
        chk("w16_ovf", c_overflow, 0);
        @(negedge clk);

        // WIDTH=16 reset pulsed mid-divide
        c_in_valid = 1; c_op = 5'b11001; c_a = 16'd100; c_b = 16'd3;
        @(negedge clk);
        c_in_valid = 0;
        repeat (5) @(negedge clk);
        r16_n = 0;
        #1;
        chk("w16_rst_valid", c_out_valid, 0);
        chk("w16_rst_res", c_result, 0);
        chk("w16_rst_hi", c_hi, 0);
        chk("w16_rst_ovf", c_overflow, 0);
        chk("w16_rst_zero", c_zero, 1);
        @(negedge clk);
        r16_n = 1;
        @(negedge clk);
        chk("w16_rst_ready", c_in_ready, 1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (c_out_valid) seen++;
            @(negedge clk);
        end
        chk("w16_rst_no_valid", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor of the execute-stage ALU. It keeps the same 5-bit operation encoding and adds correct signed overflow, set-less-than, and an iterative signed/unsigned divider producing quotient and remainder. Operands and results move through a valid/ready handshake, so the EX stage can stall on long operations. Single-cycle ops return in 1 cycle; divides return in WIDTH+1 cycles.

## Interface
- WIDTH, 32, datapath width; must be even and >= 8
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort; drops any in-flight op
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept an op this cycle
- op  input  5  operation code
- a, b  input  WIDTH  operands (a = rs, b = rt/imm)
- out_valid  output  1  result registers hold a completed op
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  main result (quotient for divides)
- hi  output  WIDTH  remainder for divides, 0 otherwise
- overflow  output  1  signed overflow (ADD/SUB only)
- zero  output  1  result == 0

## Operation
- Op codes: 00111 AND; 00001 OR; 00010 XOR; 00011 NOR; 00100 LUI = {b[WIDTH/2-1:0], WIDTH/2 zeros}; 10000 ADD; 10001 ADDU; 10010 SUB; 10011 SUBU; 10100 SLT (signed, result 0/1); 10101 SLTU; 11000 DIV; 11001 DIVU; any other code: result 0, hi 0, overflow 0, zero 1.
- ADD/SUB: overflow = (sign extension bit of the WIDTH+1-bit sum) XOR (result MSB). Result is written even when overflow = 1. All other ops: overflow 0.
- States: IDLE, DIV, DONE.
- Accept condition: in_valid & in_ready.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Accept of a single-cycle op: compute and register result, hi, overflow, zero; go to DONE.
- Accept of DIV/DIVU: latch the divisor and operand magnitudes (signed: absolute values), record quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (DIVU: both 0), load counter = WIDTH-1, go to DIV.
- DIV: one restoring step per cycle using a WIDTH+1-bit partial remainder. When the counter hits 0, apply the sign fix-ups, register the outputs, and go to DONE.
- DONE: out_valid = 1. On out_ready, either go to IDLE or, if a new op is accepted in the same cycle, follow the accept rules above. This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- Divide by zero: result = all ones, hi = a. No exception is raised.
- Signed minimum / -1: result = minimum (wraps), hi = 0, overflow = 0.
- flush: state → IDLE and out_valid → 0 next cycle, whatever the current state. Any in_valid in the same cycle is ignored. Output data registers keep their values.

## Timing
- Reset (async assert, sync deassert via the shared reset tree) sets: state IDLE, out_valid 0, result 0, hi 0, overflow 0, zero 1, counter 0. in_ready is 1 from the first cycle after reset.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N+1 (registered).
- Divide accepted at edge N: DIV for WIDTH cycles, then out_valid = 1 after edge N+WIDTH+1.
- While out_valid & !out_ready: result, hi, overflow, and zero are held stable, and in_ready = 0.
- in_ready = 0 throughout DIV.
- zero is registered together with result, never computed from a stale value.
- Reset asserted mid-divide: the op is abandoned immediately and all outputs take their reset values.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF b=1 → result 0x80000000, overflow 1, out_valid one cycle after accept. ADDU with the same operands → overflow 0.
- SLT a=0xFFFFFFFF b=1 → 1; SLTU with the same operands → 0; SUB a=5 b=5 → result 0, zero 1.
- DIV a=-7 b=2 → result 0xFFFFFFFD, hi 0xFFFFFFFF, out_valid exactly 33 cycles after accept. DIVU a=7 b=0 → result 0xFFFFFFFF, hi 7.
- Back-to-back: in_valid held with out_ready = 1, ops AND, OR, LUI (b=0x1234) → three results on consecutive cycles, the last = 0x12340000. Holding out_ready = 0 keeps the first result stable and in_ready = 0.
- flush at DIV cycle 10 → out_valid never rises, in_ready = 1 next cycle. A new ADD 2+3 then returns 5.
- WIDTH=16, DIV a=0x8000 b=0xFFFF → result 0x8000, hi 0, 17-cycle latency. resetn pulsed mid-divide → all outputs at reset values.
